// File: rtl/mux_gate_unit.sv
// Registered per-lane 2-input gate: each lane indexes a 4-bit truth table with {a, b}.
// Valid/ready on both sides, optional accumulate feedback and a handshake counter.
module mux_gate_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_op,
  input  logic [3:0]       cfg_lut,
  input  logic             cfg_acc,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [CNT_W-1:0] txn_count
);

  logic [2:0]       op_q, op_d;
  logic [3:0]       lut_q, lut_d;
  logic             acc_en_q, acc_en_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0]       lut_sel;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] y_calc;
  logic             accept;
  logic             out_hs;

  assign in_ready  = !valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign out_hs    = valid_q && out_ready;
  assign out_valid = valid_q;
  assign out_y     = y_q;
  assign txn_count = cnt_q;

  // Truth tables are indexed {a, b}, so bit 3 is the a=1,b=1 entry.
  always_comb begin
    lut_sel = 4'b1000;
    case (op_q)
      3'd0: lut_sel = 4'b1000;
      3'd1: lut_sel = 4'b1110;
      3'd2: lut_sel = 4'b0011;
      3'd3: lut_sel = 4'b0111;
      3'd4: lut_sel = 4'b0001;
      3'd5: lut_sel = 4'b0110;
      3'd6: lut_sel = 4'b1001;
      default: lut_sel = lut_q;
    endcase
  end

  assign b_eff = acc_en_q ? acc_q : in_b;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
      assign y_calc[gi] = lut_sel[{in_a[gi], b_eff[gi]}];
    end
  endgenerate

  always_comb begin
    op_d     = op_q;
    lut_d    = lut_q;
    acc_en_d = acc_en_q;
    acc_d    = acc_q;
    y_d      = y_q;
    valid_d  = valid_q;
    cnt_d    = cnt_q;

    // Config takes effect on the following cycle; this cycle's beat uses op_q.
    if (cfg_we) begin
      op_d     = cfg_op;
      lut_d    = cfg_lut;
      acc_en_d = cfg_acc;
    end

    if (cfg_we && cfg_acc) begin
      acc_d = '0;
    end else if (accept) begin
      acc_d = y_calc;
    end

    if (accept) begin
      y_d     = y_calc;
      valid_d = 1'b1;
    end else if (out_hs) begin
      valid_d = 1'b0;
    end

    if (out_hs) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= '0;
      lut_q    <= '0;
      acc_en_q <= 1'b0;
      acc_q    <= '0;
      y_q      <= '0;
      valid_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      op_q     <= op_d;
      lut_q    <= lut_d;
      acc_en_q <= acc_en_d;
      acc_q    <= acc_d;
      y_q      <= y_d;
      valid_q  <= valid_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mux_gate_unit.sv
// Bench for mux_gate_unit: scenario tasks push expected results on accept,
// a negedge monitor pops and compares them on each output handshake.
module tb_mux_gate_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_op = 3'd0;
  logic [3:0] cfg_lut = 4'd0;
  logic       cfg_acc = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = 8'h00;
  logic [7:0] in_b = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_y;
  logic [3:0] txn_count;

  int total = 0;
  int bad = 0;
  logic [7:0] sb[$];
  logic [3:0] exp_cnt = 4'd0;

  mux_gate_unit #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_op(cfg_op), .cfg_lut(cfg_lut), .cfg_acc(cfg_acc),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  // Scoreboard: a handshake completes on the next rising edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output out_y=%h with empty scoreboard", out_y);
      end else begin
        logic [7:0] e;
        e = sb.pop_front();
        if (out_y !== e) begin
          bad++;
          $display("FAIL out_y got=%h expected=%h", out_y, e);
        end else begin
          $display("beat out_y=%h ok", out_y);
        end
      end
      exp_cnt <= exp_cnt + 4'd1;
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [7:0] e);
    int n;
    n = 0;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 30) begin
      n++;
      @(negedge clk);
    end
    total++;
    if (!in_ready) begin
      bad++;
      $display("FAIL send_timeout a=%h in_ready=%b required 1", a, in_ready);
    end else begin
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      n++;
      @(negedge clk);
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout pending=%0d required 0", sb.size());
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic load_cfg(input logic [2:0] op, input logic [3:0] lut, input logic acc);
    cfg_op = op;
    cfg_lut = lut;
    cfg_acc = acc;
    cfg_we = 1'b1;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    sb.delete();
    exp_cnt = 4'd0;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    in_valid = 1'b1;
    in_a = 8'hF0;
    in_b = 8'hCC;
    repeat (2) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL reset_out_valid got=%b expected=0", out_valid);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || out_y !== 8'h00 || txn_count !== 4'd0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_state valid=%b y=%h cnt=%0d rdy=%b expected 0 00 0 1",
               out_valid, out_y, txn_count, in_ready);
    end
    @(posedge clk); #1;
    send(8'hF0, 8'hCC, 8'hC0);
    drain();
    total++;
    if (txn_count !== 4'd1) begin
      bad++;
      $display("FAIL reset_txn_count got=%0d expected=1", txn_count);
    end
    $display("test_reset done");
  endtask

  task automatic test_fixed_gates();
    logic [7:0] exp_tab[7];
    exp_tab = '{8'hC0, 8'hFC, 8'h0F, 8'h3F, 8'h03, 8'h3C, 8'hC3};
    for (int op = 0; op < 7; op++) begin
      load_cfg(3'(op), 4'd0, 1'b0);
      send(8'hF0, 8'hCC, exp_tab[op]);
    end
    drain();
    $display("test_fixed_gates done");
  endtask

  task automatic test_custom_lut();
    // Config is XNOR here; the beat in the cfg_we cycle must still see XNOR.
    cfg_op = 3'd7;
    cfg_lut = 4'b0100;
    cfg_acc = 1'b0;
    cfg_we = 1'b1;
    send(8'hF0, 8'hCC, 8'hC3);
    cfg_we = 1'b0;
    send(8'hF0, 8'hCC, 8'h30);
    drain();
    $display("test_custom_lut done");
  endtask

  task automatic test_accumulate();
    load_cfg(3'd5, 4'd0, 1'b1);
    send(8'h01, 8'hAA, 8'h01);
    send(8'h02, 8'h55, 8'h03);
    send(8'h04, 8'hAA, 8'h07);
    send(8'h08, 8'h55, 8'h0F);
    drain();
    load_cfg(3'd5, 4'd0, 1'b1);
    send(8'h01, 8'hAA, 8'h01);
    drain();
    $display("test_accumulate done");
  endtask

  task automatic test_backpressure();
    load_cfg(3'd0, 4'd0, 1'b0);
    out_ready = 1'b0;
    fork
      begin
        send(8'hFF, 8'h11, 8'h11);
        send(8'hFF, 8'h22, 8'h22);
        send(8'hFF, 8'h33, 8'h33);
      end
      begin
        @(posedge clk); #1;
        repeat (5) begin
          @(negedge clk);
          total++;
          if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_y !== 8'h11 || sb.size() != 1) begin
            bad++;
            $display("FAIL stall rdy=%b valid=%b y=%h queued=%0d expected 0 1 11 1",
                     in_ready, out_valid, out_y, sb.size());
          end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (3) begin
          @(negedge clk);
          total++;
          if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL drain_rate out_valid=%b expected=1", out_valid);
          end
        end
      end
    join
    drain();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL after_drain out_valid=%b expected=0", out_valid);
    end
    $display("test_backpressure done");
  endtask

  task automatic test_wrap_and_reset();
    pulse_reset();
    for (int i = 0; i < 17; i++) begin
      send(8'(i), 8'hFF, 8'(i));
    end
    drain();
    total++;
    if (txn_count !== 4'd1 || txn_count !== exp_cnt) begin
      bad++;
      $display("FAIL txn_wrap got=%0d expected=1", txn_count);
    end
    out_ready = 1'b0;
    send(8'hAA, 8'hFF, 8'hAA);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || txn_count !== 4'd0) begin
      bad++;
      $display("FAIL midop_reset valid=%b cnt=%0d expected 0 0", out_valid, txn_count);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    $display("test_wrap_and_reset done");
  endtask

  initial begin
    test_reset();
    test_fixed_gates();
    test_custom_lut();
    test_accumulate();
    test_backpressure();
    test_wrap_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
